// File: rtl/hazard_scoreboard_pkg.sv
// Types and constants shared by the hazard scoreboard and its per-register trackers.
`include "architecture.vh"

package hazard_scoreboard_pkg;

    localparam int TRACK_W = 4;

    typedef logic [`OP_WB_SIZE-1:0] wb_mode_t;

    localparam wb_mode_t WB_MEM = `WB_MEMORY;
    localparam wb_mode_t WB_REG = `WB_REGISTER;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EXEC,
        FWD_WB_REG,
        FWD_WB_MEM
    } fwd_sel_t;

    // Countdown preset for a newly issued load; latency 1 yields 0 (never pending).
    function automatic logic [TRACK_W-1:0] load_preset(input int latency);
        return TRACK_W'(latency - 1);
    endfunction

endpackage

// File: rtl/architecture.vh
// Shared architecture constants: datapath widths and writeback-mode encodings.
`ifndef ARCHITECTURE_VH
`define ARCHITECTURE_VH
`define DATA_SIZE   32
`define GPR_SIZE    5
`define OP_WB_SIZE  2
`define WB_NONE     2'd0
`define WB_REGISTER 2'd1
`define WB_MEMORY   2'd2
`endif

// File: rtl/hazard_scoreboard_load_tracker.sv
// Per-register load countdown; pending while the count is nonzero.
module load_tracker
    import hazard_scoreboard_pkg::*;
#(
    parameter int LOAD_LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clear,
    input  logic flush,
    output logic pending
);

    logic [TRACK_W-1:0] count_reg;

    // Flush beats a new issue, which beats early completion, which beats decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (flush) begin
            count_reg <= '0;
        end else if (set) begin
            count_reg <= load_preset(LOAD_LATENCY);
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign pending = (count_reg != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Operand forwarding and load-use stall detection with per-register load tracking.
`include "architecture.vh"

module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH   = `DATA_SIZE,
    parameter int ADDR_WIDTH   = `GPR_SIZE,
    parameter int READ_PORTS   = 2,
    parameter int LOAD_LATENCY = 2,
    parameter int CNT_WIDTH    = 16,
    localparam int NREG        = 2 ** ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             stat_clear,
    input  logic                             exec_valid,
    input  logic                             exec_is_load,
    input  logic [ADDR_WIDTH-1:0]            exec_dest,
    input  logic [DATA_WIDTH-1:0]            exec_result,
    input  logic                             wb_valid,
    input  logic [`OP_WB_SIZE-1:0]           writeback,
    input  logic [ADDR_WIDTH-1:0]            wb_dest,
    input  logic [DATA_WIDTH-1:0]            wb_result,
    input  logic [DATA_WIDTH-1:0]            wb_data_in,
    input  logic                             load_done,
    input  logic [ADDR_WIDTH-1:0]            load_done_dest,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr,
    input  logic [READ_PORTS*DATA_WIDTH-1:0] read_operand,
    input  logic [READ_PORTS-1:0]            read_used,
    output logic [READ_PORTS*DATA_WIDTH-1:0] result,
    output logic                             stall,
    output logic [NREG-1:0]                  pending,
    output logic [CNT_WIDTH-1:0]             stall_count
);

    logic                  exec_load;
    logic [READ_PORTS-1:0] port_stall;
    logic [CNT_WIDTH-1:0]  stall_count_reg;

    assign exec_load = exec_valid && exec_is_load;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            load_tracker #(
                .LOAD_LATENCY(LOAD_LATENCY)
            ) u_tracker (
                .clk    (clk),
                .rst_n  (rst_n),
                .set    (exec_load && (exec_dest == ADDR_WIDTH'(gi))),
                .clear  (load_done && (load_done_dest == ADDR_WIDTH'(gi))),
                .flush  (flush),
                .pending(pending[gi])
            );
        end

        for (gi = 0; gi < READ_PORTS; gi++) begin : g_port
            logic [ADDR_WIDTH-1:0] addr;
            logic [DATA_WIDTH-1:0] operand;
            logic [DATA_WIDTH-1:0] fwd_data;
            fwd_sel_t              sel;

            assign addr    = read_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign operand = read_operand[gi*DATA_WIDTH +: DATA_WIDTH];

            // A load in execute has no data yet, so only ALU results forward from there.
            always_comb begin
                sel = FWD_RF;
                if (exec_valid && !exec_is_load && (addr == exec_dest)) begin
                    sel = FWD_EXEC;
                end else if (wb_valid && (addr == wb_dest)) begin
                    if (writeback == WB_MEM) begin
                        sel = FWD_WB_MEM;
                    end else if (writeback == WB_REG) begin
                        sel = FWD_WB_REG;
                    end
                end
            end

            always_comb begin
                fwd_data = operand;
                case (sel)
                    FWD_EXEC:   fwd_data = exec_result;
                    FWD_WB_REG: fwd_data = wb_result;
                    FWD_WB_MEM: fwd_data = wb_data_in;
                    default:    fwd_data = operand;
                endcase
            end

            assign result[gi*DATA_WIDTH +: DATA_WIDTH] = fwd_data;
            assign port_stall[gi] = read_used[gi]
                && (pending[addr] || (exec_load && (addr == exec_dest)));
        end
    endgenerate

    assign stall = |port_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg <= '0;
        end else if (stat_clear) begin
            stall_count_reg <= '0;
        end else if (stall && (stall_count_reg != '1)) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: default instance plus a LOAD_LATENCY=4 / CNT_WIDTH=4 instance on shared inputs.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam int RP = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic               stat_clear;
    logic               exec_valid;
    logic               exec_is_load;
    logic [AW-1:0]      exec_dest;
    logic [DW-1:0]      exec_result;
    logic               wb_valid;
    wb_mode_t           writeback;
    logic [AW-1:0]      wb_dest;
    logic [DW-1:0]      wb_result;
    logic [DW-1:0]      wb_data_in;
    logic               load_done;
    logic [AW-1:0]      load_done_dest;
    logic [RP*AW-1:0]   read_addr;
    logic [RP*DW-1:0]   read_operand;
    logic [RP-1:0]      read_used;

    logic [RP*DW-1:0]   result;
    logic               stall;
    logic [NR-1:0]      pending;
    logic [15:0]        stall_count;
    logic [RP*DW-1:0]   result4;
    logic               stall4;
    logic [NR-1:0]      pending4;
    logic [3:0]         stall_count4;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [DW-1:0] OP0 = 32'hAAAA_0000;
    localparam logic [DW-1:0] OP1 = 32'hBBBB_0001;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP),
        .LOAD_LATENCY(2), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stat_clear(stat_clear),
        .exec_valid(exec_valid), .exec_is_load(exec_is_load),
        .exec_dest(exec_dest), .exec_result(exec_result),
        .wb_valid(wb_valid), .writeback(writeback), .wb_dest(wb_dest),
        .wb_result(wb_result), .wb_data_in(wb_data_in),
        .load_done(load_done), .load_done_dest(load_done_dest),
        .read_addr(read_addr), .read_operand(read_operand), .read_used(read_used),
        .result(result), .stall(stall), .pending(pending), .stall_count(stall_count)
    );

    hazard_scoreboard #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP),
        .LOAD_LATENCY(4), .CNT_WIDTH(4)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stat_clear(stat_clear),
        .exec_valid(exec_valid), .exec_is_load(exec_is_load),
        .exec_dest(exec_dest), .exec_result(exec_result),
        .wb_valid(wb_valid), .writeback(writeback), .wb_dest(wb_dest),
        .wb_result(wb_result), .wb_data_in(wb_data_in),
        .load_done(load_done), .load_done_dest(load_done_dest),
        .read_addr(read_addr), .read_operand(read_operand), .read_used(read_used),
        .result(result4), .stall(stall4), .pending(pending4), .stall_count(stall_count4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush          = 1'b0;
        stat_clear     = 1'b0;
        exec_valid     = 1'b0;
        exec_is_load   = 1'b0;
        exec_dest      = '0;
        exec_result    = '0;
        wb_valid       = 1'b0;
        writeback      = '0;
        wb_dest        = '0;
        wb_result      = '0;
        wb_data_in     = '0;
        load_done      = 1'b0;
        load_done_dest = '0;
        read_addr      = '0;
        read_operand   = {OP1, OP0};
        read_used      = '0;
    endtask

    task automatic issue_load(input logic [AW-1:0] r);
        exec_valid   = 1'b1;
        exec_is_load = 1'b1;
        exec_dest    = r;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pending !== '0) begin
            n_fail++;
            $display("FAIL reset_pending: got %0h expected 0", pending);
        end
        n_cmp++;
        if (stall_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall_count: got %0h expected 0", stall_count);
        end
        n_cmp++;
        if (pending4 !== '0 || stall_count4 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_dut4: got pending %0h count %0h expected 0/0", pending4, stall_count4);
        end
        n_cmp++;
        if (stall !== 1'b0 || result !== {OP1, OP0}) begin
            n_fail++;
            $display("FAIL reset_passthrough: got stall %0b result %0h expected 0 %0h", stall, result, {OP1, OP0});
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        $display("test_reset: done");
    endtask

    task automatic test_load_stall();
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        issue_load(5'd3);
        read_addr = {5'd0, 5'd3};
        read_used = 2'b01;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_stall_t: got %0b expected 1", stall);
        end
        step();
        exec_valid   = 1'b0;
        exec_is_load = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b1 || pending[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL load_stall_t1: got stall %0b pending3 %0b expected 1/1", stall, pending[3]);
        end
        step();
        wb_valid   = 1'b1;
        writeback  = WB_MEM;
        wb_dest    = 5'd3;
        wb_data_in = 32'hCAFE;
        #1;
        n_cmp++;
        if (stall !== 1'b0 || pending !== '0) begin
            n_fail++;
            $display("FAIL load_stall_t2: got stall %0b pending %0h expected 0/0", stall, pending);
        end
        n_cmp++;
        if (result[31:0] !== 32'hCAFE) begin
            n_fail++;
            $display("FAIL load_wb_forward: got %0h expected cafe", result[31:0]);
        end
        n_cmp++;
        if (stall_count !== 16'd2) begin
            n_fail++;
            $display("FAIL load_stall_count: got %0d expected 2", stall_count);
        end
        step();
        idle();
        step();
        $display("test_load_stall: done");
    endtask

    task automatic test_forward();
        exec_valid  = 1'b1;
        exec_dest   = 5'd5;
        exec_result = 32'h11;
        wb_valid    = 1'b1;
        writeback   = WB_REG;
        wb_dest     = 5'd5;
        wb_result   = 32'h22;
        wb_data_in  = 32'h33;
        read_addr   = {5'd5, 5'd5};
        read_used   = 2'b11;
        #1;
        n_cmp++;
        if (result !== {32'h11, 32'h11} || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_exec_priority: got %0h stall %0b expected 11/11 stall 0", result, stall);
        end
        n_cmp++;
        if (result4 !== {32'h11, 32'h11}) begin
            n_fail++;
            $display("FAIL fwd_exec_dut4: got %0h expected 11/11", result4);
        end
        step();
        exec_valid = 1'b0;
        #1;
        n_cmp++;
        if (result !== {32'h22, 32'h22}) begin
            n_fail++;
            $display("FAIL fwd_wb_register: got %0h expected 22/22", result);
        end
        step();
        writeback = WB_MEM;
        #1;
        n_cmp++;
        if (result !== {32'h33, 32'h33}) begin
            n_fail++;
            $display("FAIL fwd_wb_memory: got %0h expected 33/33", result);
        end
        step();
        writeback = 2'd0;
        #1;
        n_cmp++;
        if (result !== {OP1, OP0}) begin
            n_fail++;
            $display("FAIL fwd_wb_other_mode: got %0h expected %0h", result, {OP1, OP0});
        end
        step();
        exec_valid  = 1'b1;
        exec_dest   = 5'd0;
        exec_result = 32'h44;
        writeback   = WB_REG;
        wb_result   = 32'h55;
        read_addr   = {5'd5, 5'd0};
        #1;
        n_cmp++;
        if (result !== {32'h55, 32'h44}) begin
            n_fail++;
            $display("FAIL fwd_mixed_ports_r0: got %0h expected 55/44", result);
        end
        step();
        exec_is_load = 1'b1;
        exec_dest    = 5'd5;
        read_addr    = {5'd5, 5'd5};
        read_used    = 2'b00;
        #1;
        n_cmp++;
        if (result !== {32'h55, 32'h55} || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_load_no_data: got %0h stall %0b expected 55/55 stall 0", result, stall);
        end
        idle();
        step();
        $display("test_forward: done");
    endtask

    task automatic test_early_done();
        issue_load(5'd2);
        read_addr = {5'd0, 5'd2};
        read_used = 2'b01;
        #1;
        n_cmp++;
        if (stall4 !== 1'b1) begin
            n_fail++;
            $display("FAIL done_stall_t: got %0b expected 1", stall4);
        end
        step();
        exec_valid     = 1'b0;
        exec_is_load   = 1'b0;
        load_done      = 1'b1;
        load_done_dest = 5'd2;
        #1;
        n_cmp++;
        if (stall4 !== 1'b1 || pending4[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL done_stall_t1: got stall %0b pending2 %0b expected 1/1", stall4, pending4[2]);
        end
        step();
        load_done = 1'b0;
        #1;
        n_cmp++;
        if (stall4 !== 1'b0 || pending4[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL done_cleared_t2: got stall %0b pending2 %0b expected 0/0", stall4, pending4[2]);
        end
        step();
        n_cmp++;
        if (pending4 !== '0) begin
            n_fail++;
            $display("FAIL done_cleared_t3: got %0h expected 0", pending4);
        end
        idle();
        $display("test_early_done: done");
    endtask

    task automatic test_flush();
        logic exp4;
        logic exp2;
        issue_load(5'd4);
        step();
        flush     = 1'b1;
        read_addr = {5'd0, 5'd4};
        read_used = 2'b01;
        #1;
        n_cmp++;
        if (pending4[4] !== 1'b1 || stall4 !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_before: got pending4 %0b stall %0b expected 1/1", pending4[4], stall4);
        end
        step();
        idle();
        #1;
        n_cmp++;
        if (pending4 !== '0 || pending !== '0) begin
            n_fail++;
            $display("FAIL flush_cleared: got %0h / %0h expected 0/0", pending4, pending);
        end
        issue_load(5'd4);
        flush     = 1'b1;
        read_addr = {5'd0, 5'd4};
        read_used = 2'b01;
        #1;
        n_cmp++;
        if (stall4 !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_exec_stall_kept: got %0b expected 1", stall4);
        end
        step();
        idle();
        n_cmp++;
        if (pending4[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_same_cycle_load: got %0b expected 0", pending4[4]);
        end
        issue_load(5'd7);
        step();
        idle();
        for (int k = 1; k <= 4; k++) begin
            exp4 = (k <= 3);
            exp2 = (k == 1);
            n_cmp++;
            if (pending4[7] !== exp4 || pending[7] !== exp2) begin
                n_fail++;
                $display("FAIL countdown_k%0d: got %0b/%0b expected %0b/%0b", k, pending4[7], pending[7], exp4, exp2);
            end
            step();
        end
        $display("test_flush: done");
    endtask

    task automatic test_read_used();
        issue_load(5'd6);
        read_addr = {5'd6, 5'd6};
        read_used = 2'b00;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL unused_exec_load: got %0b expected 0", stall);
        end
        step();
        exec_valid   = 1'b0;
        exec_is_load = 1'b0;
        #1;
        n_cmp++;
        if (pending[6] !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL unused_pending: got pending6 %0b stall %0b expected 1/0", pending[6], stall);
        end
        read_used = 2'b10;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL port1_pending_stall: got %0b expected 1", stall);
        end
        read_addr = {5'd8, 5'd6};
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL port1_other_reg: got %0b expected 0", stall);
        end
        idle();
        step();
        $display("test_read_used: done");
    endtask

    task automatic test_saturate();
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        n_cmp++;
        if (stall_count4 !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_clear_start: got %0d expected 0", stall_count4);
        end
        issue_load(5'd9);
        read_addr = {5'd0, 5'd9};
        read_used = 2'b01;
        for (int k = 0; k < 14; k++) step();
        n_cmp++;
        if (stall_count4 !== 4'd14) begin
            n_fail++;
            $display("FAIL sat_count_14: got %0d expected 14", stall_count4);
        end
        for (int k = 0; k < 6; k++) step();
        n_cmp++;
        if (stall_count4 !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_count_20: got %0d expected 15", stall_count4);
        end
        stat_clear = 1'b1;
        #1;
        n_cmp++;
        if (stall4 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_stall_during_clear: got %0b expected 1", stall4);
        end
        step();
        n_cmp++;
        if (stall_count4 !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_clear_priority: got %0d expected 0", stall_count4);
        end
        idle();
        flush = 1'b1;
        step();
        idle();
        $display("test_saturate: done");
    endtask

    task automatic test_async_reset();
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        issue_load(5'd1);
        read_addr = {5'd0, 5'd1};
        read_used = 2'b01;
        step();
        idle();
        n_cmp++;
        if (pending4[1] !== 1'b1 || stall_count4 !== 4'd1) begin
            n_fail++;
            $display("FAIL areset_setup: got pending1 %0b count %0d expected 1/1", pending4[1], stall_count4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pending4 !== '0 || stall_count4 !== 4'd0) begin
            n_fail++;
            $display("FAIL areset_dut4: got pending %0h count %0d expected 0/0", pending4, stall_count4);
        end
        n_cmp++;
        if (pending !== '0 || stall_count !== 16'd0) begin
            n_fail++;
            $display("FAIL areset_dut: got pending %0h count %0d expected 0/0", pending, stall_count);
        end
        #1;
        rst_n = 1'b1;
        step();
        issue_load(5'd1);
        step();
        idle();
        n_cmp++;
        if (pending4[1] !== 1'b1 || pending[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_resume: got %0b/%0b expected 1/1", pending4[1], pending[1]);
        end
        $display("test_async_reset: done");
    endtask

    initial begin
        test_reset();
        test_load_stall();
        test_forward();
        test_early_done();
        test_flush();
        test_read_used();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- DATA_WIDTH, `DATA_SIZE: operand width.
- ADDR_WIDTH, `GPR_SIZE: register address width; NREG = 2**ADDR_WIDTH.
- READ_PORTS, 2: number of forwarded read ports.
- LOAD_LATENCY, 2: cycles from a load in execute to its data on the writeback path; legal range 1..15.
- CNT_WIDTH, 16: stall statistics counter width.

REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- flush, in, 1: squash all pending loads.
- stat_clear, in, 1: zero stall_count.
- exec_valid, in, 1: the execute stage holds an instruction.
- exec_is_load, in, 1: the execute instruction is a LOAD.
- exec_dest, in, ADDR_WIDTH: execute destination register.
- exec_result, in, DATA_WIDTH: execute ALU result.
- wb_valid, in, 1: the writeback stage holds an instruction.
- writeback, in, `OP_WB_SIZE: writeback mode.
- wb_dest, in, ADDR_WIDTH: writeback destination register.
- wb_result, in, DATA_WIDTH: writeback register result.
- wb_data_in, in, DATA_WIDTH: writeback memory data.
- load_done, in, 1: memory reports early completion of a load.
- load_done_dest, in, ADDR_WIDTH: destination of the completed load.
- read_addr, in, READ_PORTS*ADDR_WIDTH: flat source addresses; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- read_operand, in, READ_PORTS*DATA_WIDTH: flat register-file operands.
- read_used, in, READ_PORTS: port p actually consumes its operand.
- result, out, READ_PORTS*DATA_WIDTH: flat forwarded operands.
- stall, out, 1: hold the read stage.
- pending, out, NREG: pending-load bitmap.
- stall_count, out, CNT_WIDTH: saturating count of stall cycles.

Function
REQ-003 Each port p SHALL select its result combinationally, in this priority order:
- exec_valid && !exec_is_load && addr==exec_dest: exec_result.
- Else wb_valid && addr==wb_dest: wb_data_in for `WB_MEMORY, wb_result for `WB_REGISTER, otherwise read_operand.
- Else: read_operand.
REQ-004 An execute-stage LOAD SHALL never supply forwarded data.
REQ-005 Each register SHALL own a 4-bit countdown; pending[r] = (count[r] != 0).
REQ-006 When exec_valid && exec_is_load, the clock edge SHALL load count[exec_dest] with LOAD_LATENCY-1; with LOAD_LATENCY=1 no pending bit is ever set.
REQ-007 Every nonzero count SHALL decrement by 1 per cycle.
REQ-008 load_done SHALL zero count[load_done_dest] at the clock edge.
REQ-009 Simultaneous events SHALL resolve as: flush > new load issue to the same register > load_done > decrement.
REQ-010 stall SHALL be combinational: OR over p of read_used[p] && (pending[addr_p] || (exec_valid && exec_is_load && addr_p==exec_dest)).
REQ-011 stall_count SHALL increment on each cycle with stall=1 and saturate at all-ones.
REQ-012 stat_clear SHALL have priority over increment and set stall_count to 0 at the edge.
REQ-013 flush SHALL be synchronous and zero all counts at the edge; it SHALL leave stall_count unchanged and does not mask the combinational execute-stage stall term.
REQ-014 Register-file operands SHALL be used unmodified when no forwarding or stall condition applies; register 0 SHALL get no special treatment.

Reset
REQ-015 rst_n low SHALL immediately zero all counts, pending and stall_count, independent of clk.
REQ-016 The block SHALL resume normal operation on the first clock edge after rst_n deasserts.
REQ-017 result and stall SHALL remain purely combinational functions of the inputs and state.

Structure
REQ-018 `WB_MEMORY, `WB_REGISTER and `OP_WB_SIZE SHALL come from the shared architecture.vh header; no local redefinition is allowed.
REQ-019 The per-register countdown SHALL be a sub-module load_tracker (inputs: set, clear, flush; outputs: pending), instantiated NREG times via generate.
REQ-020 Forwarding muxes SHALL be generated per port; no per-port hand-written code is allowed.

Verification (default parameters unless stated)
REQ-021 Load r3 in execute at cycle t, read_addr0=3, read_used0=1 -> stall=1 at t and t+1, stall=0 at t+2; at t+2 with writeback=`WB_MEMORY, wb_dest=3, wb_data_in=0xCAFE -> result0=0xCAFE; stall_count=2.
REQ-022 exec ALU r5=0x11, wb `WB_REGISTER r5=0x22, both ports read 5 -> result0=result1=0x11, stall=0.
REQ-023 LOAD_LATENCY=4: load r2 at t, load_done r2 at t+1 -> stall at t and t+1 only; pending[2]=0 from t+2.
REQ-024 LOAD_LATENCY=4: load r4 at t, flush at t+1 -> pending[4]=0 from t+2; same-cycle load plus flush -> pending stays 0.
REQ-025 read_used0=0 on pending r6 -> stall=0; CNT_WIDTH=4 with 20 consecutive stall cycles -> stall_count=15; stat_clear -> 0.
REQ-026 rst_n pulsed low mid-pending between edges -> pending=0 and stall_count=0 immediately.
